// File: rtl/tc_sequencer_if.sv
// tc_sequencer_if: register write port of one TC timer plus its interrupt line.
//   tc_we_o   TC write enable
//   tc_add_o  TC register address [3:2]: 00 CTRL, 01 PRESET, 10 COUNT
//   tc_dat_o  TC write data
//   tc_irq_i  TC interrupt back to the driver
// master: the side that writes the TC (the sequencer); slave: the TC itself.
interface tc_sequencer_if;
  logic        tc_we_o;
  logic [1:0]  tc_add_o;
  logic [31:0] tc_dat_o;
  logic        tc_irq_i;

  modport master (output tc_we_o, output tc_add_o, output tc_dat_o, input tc_irq_i);
  modport slave  (input tc_we_o, input tc_add_o, input tc_dat_o, output tc_irq_i);
endinterface

// File: rtl/tc_sequencer.sv
// tc_sequencer: runs a table of SLOTS one-shot countdowns on one TC timer, back to back.
// Each slot programs the TC (CTRL off, PRESET, CTRL arm), waits for its irq, then acks it
// and pulses tick_o. A zero entry ends the sequence; loop_i wraps after the last slot.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   cfg_we_i/idx_i/dat_i slot table write (allowed in any state)
//   start_i, stop_i      start from slot 0 (IDLE only), abort running sequence
//   loop_i               wrap from the last slot to slot 0 instead of finishing
//   busy_o, done_o       not IDLE; 1-cycle completion pulse (first IDLE cycle)
//   tick_o, err_o        expiry pulse during ACK; sticky WAIT-timeout flag
//   slot_o               current slot index
//   tc                   TC register write port and irq (master side)
module tc_sequencer #(
  parameter int unsigned SLOTS   = 4,
  parameter int unsigned IDXW    = 2,
  parameter logic [31:0] TIMEOUT = 32'hFFFF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_we_i,
  input  logic [IDXW-1:0] cfg_idx_i,
  input  logic [31:0]     cfg_dat_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            loop_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            tick_o,
  output logic            err_o,
  output logic [IDXW-1:0] slot_o,
  tc_sequencer_if.master  tc
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CTRL_OFF, S_PST, S_ARM, S_WAIT, S_ACK, S_ABORT
  } state_t;

  localparam logic [IDXW-1:0] LAST_SLOT = IDXW'(SLOTS - 1);
  localparam logic [31:0]     TO_LAST   = TIMEOUT - 32'd1;
  localparam logic [31:0]     CTRL_RUN  = 32'h9;  // IM_EN | MODE_0 | EN

  state_t      state;
  logic [31:0] slot_tab [SLOTS];
  logic [31:0] preset;
  logic [31:0] wait_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      slot_o   <= '0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      preset   <= '0;
      wait_cnt <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) slot_tab[i] <= '0;
    end else begin
      if (cfg_we_i) slot_tab[cfg_idx_i] <= cfg_dat_i;
      done_o <= 1'b0;
      // stop overrides every busy state's own transition, ABORT excepted
      if (stop_i && state != S_IDLE && state != S_ABORT) begin
        state <= S_ABORT;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !stop_i) begin
              state  <= S_LOAD;
              slot_o <= '0;
              err_o  <= 1'b0;
            end
          end
          S_LOAD: begin
            preset <= slot_tab[slot_o];
            if (slot_tab[slot_o] == '0) begin
              state  <= S_IDLE;
              done_o <= 1'b1;
            end else begin
              state <= S_CTRL_OFF;
            end
          end
          S_CTRL_OFF: state <= S_PST;
          S_PST:      state <= S_ARM;
          S_ARM: begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (tc.tc_irq_i) begin
              state <= S_ACK;
            end else if (TIMEOUT != '0 && wait_cnt == TO_LAST) begin
              err_o <= 1'b1;
              state <= S_ABORT;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
          end
          S_ACK: begin
            if (slot_o != LAST_SLOT) begin
              slot_o <= slot_o + 1'b1;
              state  <= S_LOAD;
            end else if (loop_i) begin
              slot_o <= '0;
              state  <= S_LOAD;
            end else begin
              done_o <= 1'b1;
              state  <= S_IDLE;
            end
          end
          S_ABORT: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o = (state != S_IDLE);
  // a stop in ACK turns it into an abort, so the tick is withheld in that cycle
  assign tick_o = (state == S_ACK) && !stop_i;

  always_comb begin
    tc.tc_we_o  = 1'b0;
    tc.tc_add_o = 2'b00;
    tc.tc_dat_o = '0;
    case (state)
      S_CTRL_OFF, S_ACK, S_ABORT: tc.tc_we_o = 1'b1;
      S_PST: begin
        tc.tc_we_o  = 1'b1;
        tc.tc_add_o = 2'b01;
        tc.tc_dat_o = preset;
      end
      S_ARM: begin
        tc.tc_we_o  = 1'b1;
        tc.tc_dat_o = CTRL_RUN;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tc_sequencer.sv
// tb_tc_sequencer: directed bench for tc_sequencer with a behavioural TC on the bus.
// Expected TC writes, ticks and done pulses are queued as stimulus is issued and
// checked in order by a monitor on the falling clock edge.
module tb_tc_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_dat = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        busy, done, tick, err;
  logic [1:0]  slot;

  int n_cmp = 0;
  int n_bad = 0;
  int n_tick = 0;

  localparam int K_WR = 0, K_TICK = 1, K_DONE = 2;
  typedef struct {
    int          kind;
    logic [1:0]  add;
    logic [31:0] dat;
  } ev_t;
  ev_t q[$];
  ev_t mon_e;

  tc_sequencer_if bus ();

  // behavioural TC: one-shot countdown, irq when it expires with IM_EN set
  logic        mute = 1'b0;
  logic [31:0] m_ctrl, m_cnt;
  logic        m_irq;
  assign bus.tc_irq_i = m_irq & ~mute;

  always @(posedge clk) begin
    if (rst) begin
      m_ctrl <= '0;
      m_cnt  <= '0;
      m_irq  <= 1'b0;
    end else begin
      if (bus.tc_we_o && bus.tc_add_o == 2'b00) m_ctrl <= bus.tc_dat_o;
      if (bus.tc_we_o && bus.tc_add_o == 2'b01) m_cnt <= bus.tc_dat_o;
      if (bus.tc_we_o && bus.tc_add_o == 2'b00) begin
        m_irq <= 1'b0;
      end else if (m_ctrl[0] && m_cnt != 0 && !bus.tc_we_o) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && m_ctrl[3]) m_irq <= 1'b1;
      end
    end
  end

  tc_sequencer #(.SLOTS(4), .IDXW(2), .TIMEOUT(32'd8)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_dat_i(cfg_dat),
    .start_i(start), .stop_i(stop), .loop_i(loop), .busy_o(busy), .done_o(done),
    .tick_o(tick), .err_o(err), .slot_o(slot), .tc(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [1:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.add  = a;
    e.dat  = d;
    q.push_back(e);
  endtask

  task automatic push_head(input logic [31:0] p);
    push(K_WR, 2'b00, 32'h0);
    push(K_WR, 2'b01, p);
    push(K_WR, 2'b00, 32'h9);
  endtask

  task automatic push_slot(input logic [1:0] s, input logic [31:0] p);
    push_head(p);
    push(K_WR, 2'b00, 32'h0);
    push(K_TICK, 2'b00, {30'd0, s});
  endtask

  task automatic cfg(input logic [1:0] i, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = i; cfg_dat = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      step();
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic wait_irq(input int budget);
    int i = 0;
    while (bus.tc_irq_i && i < budget) begin step(); i++; end
    while (!bus.tc_irq_i && i < budget) begin step(); i++; end
    chk("irq_wait", bus.tc_irq_i, 1);
  endtask

  task automatic wait_arm(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.tc_we_o && bus.tc_add_o == 2'b00 && bus.tc_dat_o == 32'h9) break;
      step();
    end
    chk("arm_wait", bus.tc_we_o && bus.tc_dat_o == 32'h9, 1);
  endtask

  // in-order scoreboard: write, then tick, then done within one cycle
  always @(negedge clk) begin
    if (bus.tc_we_o) begin
      chk("wr_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("wr_kind", K_WR, mon_e.kind);
        chk("wr_add", bus.tc_add_o, mon_e.add);
        chk("wr_dat", bus.tc_dat_o, mon_e.dat);
      end
    end
    if (tick) begin
      n_tick++;
      chk("tick_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("tick_kind", K_TICK, mon_e.kind);
        chk("tick_slot", slot, mon_e.dat);
      end
    end
    if (done) begin
      chk("done_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("done_kind", K_DONE, mon_e.kind);
      end
    end
  end

  initial begin
    int t0;
    int n;

    // 1 reset
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    chk("rst_err", err, 0);
    chk("rst_slot", slot, 0);
    chk("rst_we", bus.tc_we_o, 0);
    rst = 1'b0;
    step();

    // 2 single run {3,2,0,x}, start while busy ignored
    cfg(2'd0, 32'd3);
    cfg(2'd1, 32'd2);
    cfg(2'd2, 32'd0);
    loop = 1'b0;
    push_slot(2'd0, 32'd3);
    push_slot(2'd1, 32'd2);
    push(K_DONE, 2'b00, 32'h0);
    t0 = n_tick;
    pulse_start();
    step();
    step();
    pulse_start();
    wait_idle(200);
    step();
    chk("single_q_empty", q.size(), 0);
    chk("single_ticks", n_tick - t0, 2);
    chk("single_err", err, 0);

    // 3 full table with loop, stop in WAIT of slot 1 on the second pass
    for (int i = 0; i < 4; i++) cfg(2'(i), 32'd2);
    loop = 1'b1;
    for (int i = 0; i < 4; i++) push_slot(2'(i), 32'd2);
    push_slot(2'd0, 32'd2);
    push_head(32'd2);
    push(K_WR, 2'b00, 32'h0);
    t0 = n_tick;
    pulse_start();
    for (int i = 0; i < 5; i++) wait_irq(100);
    wait_arm(100);
    chk("loop_slot_at_stop", slot, 1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(20);
    step();
    step();
    step();
    chk("loop_q_empty", q.size(), 0);
    chk("loop_ticks", n_tick - t0, 5);
    chk("loop_irq_after_abort", bus.tc_irq_i, 0);

    // 4 timeout with irq held low
    loop = 1'b0;
    mute = 1'b1;
    cfg(2'd0, 32'd3);
    push_head(32'd3);
    push(K_WR, 2'b00, 32'h0);
    pulse_start();
    n = 0;
    while (busy && n < 100) begin n++; step(); end
    chk("to_busy_cycles", n, 13);
    chk("to_err", err, 1);
    step();
    step();
    step();
    chk("to_err_sticky", err, 1);
    chk("to_q_empty", q.size(), 0);
    mute = 1'b0;

    // 5 boundaries: end marker at slot 0, start&stop in IDLE
    cfg(2'd0, 32'd0);
    push(K_DONE, 2'b00, 32'h0);
    pulse_start();
    chk("mark_busy", busy, 1);
    chk("mark_err_cleared", err, 0);
    chk("mark_done_early", done, 0);
    step();
    chk("mark_done", done, 1);
    chk("mark_idle", busy, 0);
    step();
    chk("mark_done_pulse", done, 0);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_idle", busy, 0);
    step();
    step();
    chk("startstop_still_idle", busy, 0);
    chk("bound_q_empty", q.size(), 0);

    // 6 races: table write during WAIT, stop in ACK of the last slot
    for (int i = 0; i < 4; i++) cfg(2'(i), 32'd2);
    loop = 1'b1;
    for (int i = 0; i < 4; i++) push_slot(2'(i), 32'd2);
    push_slot(2'd0, 32'd4);
    push_slot(2'd1, 32'd2);
    push_slot(2'd2, 32'd2);
    push_head(32'd2);
    push(K_WR, 2'b00, 32'h0);
    push(K_WR, 2'b00, 32'h0);
    t0 = n_tick;
    pulse_start();
    wait_irq(100);
    cfg(2'd0, 32'd4);
    for (int i = 0; i < 7; i++) wait_irq(100);
    step();
    stop = 1'b1;
    #1;
    chk("ack_stop_slot", slot, 3);
    chk("ack_stop_tick", tick, 0);
    step();
    stop = 1'b0;
    wait_idle(20);
    step();
    step();
    chk("race_q_empty", q.size(), 0);
    chk("race_ticks", n_tick - t0, 7);
    chk("race_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
